// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encodings and default width.
package seq_shift_add_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mul_state_t;

endpackage

// File: rtl/seq_shift_add_multiplier_cba_adder.sv
// Parametrised carry-bypass adder: 4-bit ripple blocks whose carry skips the block when
// every bit propagates.
module cba_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int BLK = 4;
    localparam int NB  = (WIDTH + BLK - 1) / BLK;
    localparam int PW  = NB * BLK;

    logic [PW-1:0]    w_xp;
    logic [PW-1:0]    w_yp;
    logic [WIDTH-1:0] w_s;
    logic             w_co;

    // Pad bits are zero, so they never propagate and never disturb the top carry.
    assign w_xp = PW'(x);
    assign w_yp = PW'(y);

    always_comb begin
        logic v_c;
        logic v_cb;
        logic v_allp;
        logic v_p;
        logic v_g;
        int   v_idx;
        w_s    = '0;
        w_co   = 1'b0;
        v_c    = cin;
        v_cb   = 1'b0;
        v_allp = 1'b0;
        v_p    = 1'b0;
        v_g    = 1'b0;
        v_idx  = 0;
        for (int blk = 0; blk < NB; blk++) begin
            v_cb   = v_c;
            v_allp = 1'b1;
            for (int j = 0; j < BLK; j++) begin
                v_idx  = blk * BLK + j;
                v_p    = w_xp[v_idx] ^ w_yp[v_idx];
                v_g    = w_xp[v_idx] & w_yp[v_idx];
                if (v_idx < WIDTH)
                    w_s[v_idx] = v_p ^ v_c;
                v_c    = v_g | (v_p & v_c);
                v_allp = v_allp & v_p;
                if (v_idx == WIDTH - 1)
                    w_co = v_c;
            end
            if (v_allp)
                v_c = v_cb;
        end
    end

    assign sum  = w_s;
    assign cout = w_co;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-add multiplier: one partial product per clock, signed or unsigned,
// start/busy/done handshake, WIDTH+1 cycles per operation.
module seq_shift_add_multiplier
    import seq_shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    mul_state_t         r_state;
    mul_state_t         w_next;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_amag;
    logic               r_neg;
    logic [CW-1:0]      r_step;
    logic [2*WIDTH-1:0] r_product;
    logic               r_done;

    logic               w_accept;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_acc_step;

    assign w_accept = (r_state == ST_IDLE) && start;
    // Magnitudes are unsigned, so the most negative operand maps exactly to 2^(WIDTH-1).
    assign w_a_mag  = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (signed_mode && b[WIDTH-1]) ? -b : b;

    cba_adder #(.WIDTH(WIDTH)) u_adder (
        .x    (r_acc[2*WIDTH-1:WIDTH]),
        .y    (r_amag),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_acc_step = r_acc[0] ? {w_cout, w_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_CALC;
            ST_CALC: if (r_step == LAST_STEP) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_amag    <= '0;
            r_neg     <= 1'b0;
            r_step    <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_FIX);
            if (w_accept) begin
                r_neg  <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_amag <= w_a_mag;
                r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                r_step <= '0;
            end else if (r_state == ST_CALC) begin
                r_acc  <= w_acc_step;
                r_step <= r_step + 1'b1;
            end
            if (r_state == ST_FIX)
                r_product <= r_neg ? -r_acc : r_acc;
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and randomized checks of the shift-add multiplier at WIDTH=32 and WIDTH=8.
module tb_seq_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, smode;
    logic [31:0] a, b;
    logic        busy, done;
    logic [63:0] product;
    logic        start8, smode8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] product8;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(smode),
        .a(a), .b(b), .busy(busy), .done(done), .product(product));

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(smode8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref32(input logic m, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        return m ? 64'(sx * sy) : 64'(ux * uy);
    endfunction

    function automatic logic [15:0] ref8(input logic m, input logic [7:0] x, input logic [7:0] y);
        int sx, sy, ux, uy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'({24'b0, x});
        uy = int'({24'b0, y});
        return m ? 16'(sx * sy) : 16'(ux * uy);
    endfunction

    // Entered at the negedge right after the accepting edge (n=0); returns at the done negedge.
    task automatic wait_done32(input int inj, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int n = 0; n < 200; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
            if (n == inj) begin
                start = 1'b1; a = 32'd9; b = 32'd9; smode = 1'b0;
            end else if (n == inj + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic op32(input logic m, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; smode = m; a = x; b = y;
        @(negedge clk);
        start = 1'b0; smode = ~m; a = $urandom; b = $urandom;
        wait_done32(-1, lat, bcnt);
    endtask

    task automatic op8(input logic m, input logic [7:0] x, input logic [7:0] y, output int lat);
        @(negedge clk);
        start8 = 1'b1; smode8 = m; a8 = x; b8 = y;
        @(negedge clk);
        start8 = 1'b0; smode8 = ~m; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = -1;
        for (int n = 0; n < 50; n++) begin
            if (done8) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat, bcnt, seen;
        logic [31:0] x, y;
        logic [7:0]  x8, y8;
        logic        m;

        rst_n = 1'b0; start = 1'b0; smode = 1'b0; a = '0; b = '0;
        start8 = 1'b0; smode8 = 1'b0; a8 = '0; b8 = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_product8", 64'(product8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op32(1'b1, 32'd7, 32'hFFFF_FFFD, lat, bcnt);
        chk("s7xm3", product, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("s7xm3_model", product, ref32(1'b1, 32'd7, 32'hFFFF_FFFD));
        chk("s7xm3_lat", 64'(lat), 64'd33);
        chk("s7xm3_busy", 64'(bcnt), 64'd33);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);

        op32(1'b1, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
        chk("s_min_sq", product, 64'h4000_0000_0000_0000);
        op32(1'b0, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
        chk("u_min_sq", product, 64'h4000_0000_0000_0000);
        op32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("u_max_sq", product, 64'hFFFF_FFFE_0000_0001);
        op32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("s_m1_sq", product, 64'h1);

        // 5*6 with an ignored 9*9 request mid-flight, then 3*4 started on the done cycle.
        @(negedge clk);
        start = 1'b1; smode = 1'b0; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        wait_done32(10, lat, bcnt);
        chk("ign_product", product, 64'd30);
        chk("ign_lat", 64'(lat), 64'd33);
        start = 1'b1; smode = 1'b0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_hold", product, 64'd30);
        wait_done32(-1, lat, bcnt);
        chk("b2b_product", product, 64'd12);
        chk("b2b_lat", 64'(lat), 64'd33);

        for (int i = 0; i < 6; i++) begin
            x = $urandom; y = $urandom; m = 1'(i % 2);
            op32(m, x, y, lat, bcnt);
            chk("rand32", product, ref32(m, x, y));
        end

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; smode = 1'b0; a = 32'd11; b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("arst_no_done", 64'(seen), 64'd0);
        op32(1'b1, 32'd2, 32'hFFFF_FFFE, lat, bcnt);
        chk("post_rst", product, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("post_rst_lat", 64'(lat), 64'd33);

        op8(1'b0, 8'd0, 8'hB7, lat);
        chk("w8_zero", 64'(product8), 64'd0);
        chk("w8_zero_lat", 64'(lat), 64'd9);
        op8(1'b1, 8'h80, 8'h80, lat);
        chk("w8_min_sq", 64'(product8), 64'h4000);
        for (int i = 0; i < 1000; i++) begin
            m  = 1'(i % 2);
            x8 = (i % 97 == 0) ? 8'd0 : 8'($urandom);
            y8 = 8'($urandom);
            op8(m, x8, y8, lat);
            chk("w8_rand", 64'(product8), 64'(ref8(m, x8, y8)));
            chk("w8_lat", 64'(lat), 64'd9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
